// File: rtl/cpu_pkg.sv
// Shared types and defaults for the core's back-end stages.
// Imported by the write-back unit and its round-robin arbiter.
package cpu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } wb_state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers the last port
// granted and advances only when a grant is actually issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    // A lone requester always wins; on a conflict the port not served last wins.
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Port 1 counts as last-served out of reset, so the first conflict goes to port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU and LSU results onto the register-file
// write port, forwards the committed value, raises branch redirects and counts retirements.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int xlen  = XLEN_DEF,
    parameter int cnt_w = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_result_v,
    input  logic [xlen-1:0]  alu_result,
    input  logic [4:0]       alu_rd,
    input  logic             alu_branch,
    output logic             alu_ok,
    input  logic             lsu_result_v,
    input  logic [xlen-1:0]  lsu_result,
    input  logic [4:0]       lsu_rd,
    output logic             lsu_ok,
    input  logic             rf_busy,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [xlen-1:0]  rf_wdata,
    output logic             fwd_v,
    output logic [4:0]       fwd_rd,
    output logic [xlen-1:0]  fwd_data,
    output logic             redirect_v,
    output logic [xlen-1:0]  redirect_pc,
    output logic [cnt_w-1:0] instret
);

    wb_state_e        r_state;
    wb_state_e        w_next;
    logic             r_we;
    logic [4:0]       r_waddr;
    logic [xlen-1:0]  r_wdata;
    logic [xlen-1:0]  r_redirect_pc;
    logic [cnt_w-1:0] r_instret;

    logic             w_en;
    logic [1:0]       w_gnt;
    logic             w_xfer;
    logic             w_branch;
    wb_src_e          w_src;
    logic [4:0]       w_rd;

    // Grants are withheld during reset, the redirect bubble and register-file stalls.
    assign w_en = (r_state == RUN) && !rf_busy && !rst;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_req ({lsu_result_v, alu_result_v}),
        .o_gnt (w_gnt)
    );

    assign alu_ok   = w_gnt[0];
    assign lsu_ok   = w_gnt[1];
    assign w_xfer   = alu_ok || lsu_ok;
    assign w_branch = alu_ok && alu_branch;
    assign w_src    = lsu_ok ? SRC_LSU : SRC_ALU;
    assign w_rd     = (w_src == SRC_LSU) ? lsu_rd : alu_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // A taken branch costs exactly one bubble cycle in REDIRECT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:      if (w_branch) w_next = REDIRECT;
            REDIRECT: w_next = RUN;
            default:  w_next = RUN;
        endcase
    end

    // Writes to x0 still load the stage and retire, but never assert the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_waddr       <= 5'd0;
            r_wdata       <= '0;
            r_redirect_pc <= '0;
            r_instret     <= '0;
        end else begin
            r_we <= w_xfer && !w_branch && (w_rd != 5'd0);
            if (w_xfer && !w_branch) begin
                r_waddr <= w_rd;
                r_wdata <= (w_src == SRC_LSU) ? lsu_result : alu_result;
            end
            if (w_branch) begin
                r_redirect_pc <= alu_result;
            end
            if (w_xfer) begin
                r_instret <= r_instret + {{(cnt_w-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign fwd_v       = r_we;
    assign fwd_rd      = r_waddr;
    assign fwd_data    = r_wdata;
    assign redirect_v  = (r_state == REDIRECT);
    assign redirect_pc = r_redirect_pc;
    assign instret     = r_instret;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration and commit rules.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_result_v;
    logic [31:0] alu_result;
    logic [4:0]  alu_rd;
    logic        alu_branch;
    logic        alu_ok;
    logic        lsu_result_v;
    logic [31:0] lsu_result;
    logic [4:0]  lsu_rd;
    logic        lsu_ok;
    logic        rf_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_v;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        redirect_v;
    logic [31:0] redirect_pc;
    logic [63:0] instret;

    int errCount   = 0;
    int checkCount = 0;

    // Model state: what the outputs should show after the next clock edge.
    logic        mLastAlu;
    logic        mRedirect;
    logic        mWe;
    logic [4:0]  mWaddr;
    logic [31:0] mWdata;
    logic [31:0] mPc;
    logic [63:0] mInstret;

    writeback_unit #(.xlen(32), .cnt_w(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result_v (alu_result_v),
        .alu_result   (alu_result),
        .alu_rd       (alu_rd),
        .alu_branch   (alu_branch),
        .alu_ok       (alu_ok),
        .lsu_result_v (lsu_result_v),
        .lsu_result   (lsu_result),
        .lsu_rd       (lsu_rd),
        .lsu_ok       (lsu_ok),
        .rf_busy      (rf_busy),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_v        (fwd_v),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .redirect_v   (redirect_v),
        .redirect_pc  (redirect_pc),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLastAlu  = 1'b0;
        mRedirect = 1'b0;
        mWe       = 1'b0;
        mWaddr    = 5'd0;
        mWdata    = 32'd0;
        mPc       = 32'd0;
        mInstret  = 64'd0;
    endtask

    // One clock cycle: drive at the falling edge, check grants, predict, check registered outputs.
    task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] ard,
                                 input logic ab, input logic lv, input logic [31:0] ld,
                                 input logic [4:0] lrd, input logic busy, input logic rs);
        logic eA;
        logic eL;
        alu_result_v = av;
        alu_result   = ad;
        alu_rd       = ard;
        alu_branch   = ab;
        lsu_result_v = lv;
        lsu_result   = ld;
        lsu_rd       = lrd;
        rf_busy      = busy;
        rst          = rs;
        #1;
        eA = 1'b0;
        eL = 1'b0;
        if (!rs && !mRedirect && !busy) begin
            if (av && (!lv || !mLastAlu)) eA = 1'b1;
            else if (lv)                  eL = 1'b1;
        end
        checkOutput("alu_ok", 64'(alu_ok), 64'(eA));
        checkOutput("lsu_ok", 64'(lsu_ok), 64'(eL));
        if (rs) begin
            modelReset();
        end else begin
            mRedirect = eA && ab;
            mWe       = 1'b0;
            if (eA || eL) begin
                mLastAlu = eA;
                mInstret = mInstret + 64'd1;
                if (eA && ab) begin
                    mPc = ad;
                end else begin
                    mWaddr = eA ? ard : lrd;
                    mWdata = eA ? ad : ld;
                    mWe    = (mWaddr != 5'd0);
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("rf_we",       64'(rf_we),       64'(mWe));
        checkOutput("rf_waddr",    64'(rf_waddr),    64'(mWaddr));
        checkOutput("rf_wdata",    64'(rf_wdata),    64'(mWdata));
        checkOutput("fwd_v",       64'(fwd_v),       64'(mWe));
        checkOutput("fwd_rd",      64'(fwd_rd),      64'(mWaddr));
        checkOutput("fwd_data",    64'(fwd_data),    64'(mWdata));
        checkOutput("redirect_v",  64'(redirect_v),  64'(mRedirect));
        checkOutput("redirect_pc", 64'(redirect_pc), 64'(mPc));
        checkOutput("instret",     instret,          mInstret);
        @(negedge clk);
    endtask

    task automatic idle(input logic rs);
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, rs);
    endtask

    initial begin
        alu_result_v = 1'b0;
        alu_result   = '0;
        alu_rd       = '0;
        alu_branch   = 1'b0;
        lsu_result_v = 1'b0;
        lsu_result   = '0;
        lsu_rd       = '0;
        rf_busy      = 1'b0;
        rst          = 1'b1;
        modelReset();
        @(negedge clk);

        idle(1'b1);
        idle(1'b0);

        // Single ALU write to x5.
        applyStimulus(1'b1, 32'h0000_00AA, 5'd5, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("first_waddr", 64'(rf_waddr), 64'd5);
        checkOutput("first_instret", instret, 64'd1);
        idle(1'b0);

        // Fresh reset, then four conflicting cycles: ALU, LSU, ALU, LSU.
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 5'(1 + i / 2 + (i % 2) * 0), 1'b0,
                          1'b1, 32'h900 + 32'(i), 5'(9 + i / 2), 1'b0, 1'b0);
        end
        idle(1'b0);

        // Taken branch produces a one-cycle redirect with both grants low.
        applyStimulus(1'b1, 32'h8000_0100, 5'd3, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("branch_redirect", 64'(redirect_v), 64'd1);
        applyStimulus(1'b1, 32'h0000_0055, 5'd6, 1'b0, 1'b1, 32'h77, 5'd7, 1'b0, 1'b0);
        idle(1'b0);

        // Register file stalls for three cycles with an LSU entry pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'hCAFE_0001, 5'd17, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'hCAFE_0001, 5'd17, 1'b0, 1'b0);
        idle(1'b0);

        // Load to x0 retires without a write.
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        idle(1'b0);

        // Branch and LSU together: ALU wins, LSU waits out the redirect bubble.
        idle(1'b1);
        applyStimulus(1'b1, 32'h0000_4000, 5'd2, 1'b1, 1'b1, 32'h1234, 5'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h1234, 5'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h1234, 5'd8, 1'b0, 1'b0);

        // Counter wraps from all-ones to zero.
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        mInstret = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(1'b1, 32'h3, 5'd4, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("instret_wrap", instret, 64'd0);

        // Reset arriving during REDIRECT abandons it.
        applyStimulus(1'b1, 32'hDEAD_BEE0, 5'd1, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1, 5'd1, 1'b0, 1'b1, 32'h2, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1, 5'd1, 1'b0, 1'b1, 32'h2, 5'd2, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), $urandom, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 2) != 0), $urandom, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the in-order core. It sits downstream of the ALU's alu-to-wb pipeline FIFO and the load/store unit. It arbitrates between the two result channels and commits results to the register-file write port. It also exposes a one-cycle forwarding path, raises a pipeline redirect/flush when the ALU reports a taken branch, and maintains the retired-instruction counter.

## Interface
Parameters:
- xlen, 32, data/address width
- cnt_w, 64, width of retired-instruction counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- alu_result_v  in  1  ALU channel valid
- alu_result  in  xlen  ALU result; branch target when alu_branch=1
- alu_rd  in  5  ALU destination register
- alu_branch  in  1  ALU taken-branch flag
- alu_ok  out  1  ALU channel accept (drives the FIFO's ok)
- lsu_result_v  in  1  LSU channel valid
- lsu_result  in  xlen  load data
- lsu_rd  in  5  LSU destination register
- lsu_ok  out  1  LSU channel accept
- rf_busy  in  1  register file cannot take a write this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  xlen  write data
- fwd_v  out  1  forwarding entry valid (equals rf_we)
- fwd_rd  out  5  forwarded register
- fwd_data  out  xlen  forwarded value
- redirect_v  out  1  one-cycle fetch redirect / pipeline flush
- redirect_pc  out  xlen  redirect target
- instret  out  cnt_w  retired-instruction count

## Operation
- Transfer on a channel occurs when valid && ok in the same cycle. ok is never asserted to both channels in one cycle.
- ok is combinational from the state, rf_busy, the valids and the arbiter pointer. It does not depend on registered outputs of the same cycle.
- States: RUN, REDIRECT.
  - RUN: if rf_busy=1, both ok=0. Otherwise grant one valid channel.
  - Accepted ALU entry with alu_branch=1: no register write. Latch redirect_pc=alu_result and go to REDIRECT.
  - Any other accepted entry: registered write stage loads {rd, data}.
  - REDIRECT: redirect_v=1 for exactly one cycle. Both ok=0, then return to RUN.
- Arbitration is round-robin. The last_grant pointer updates only on a transfer.
  - Single valid channel wins regardless of pointer.
  - When both are valid, the channel not granted last wins.
  - Reset value last_grant=LSU, so the first conflict goes to ALU.
- rd=0: the entry is accepted and counted, but rf_we stays 0 and fwd_v stays 0.
- instret increments by 1 on every transfer, including branches and rd=0. It wraps modulo 2^cnt_w.
- Reset: state=RUN, last_grant=LSU.
  - Outputs rf_we=0, rf_waddr=0, rf_wdata=0, fwd_v=0, fwd_rd=0, fwd_data=0, redirect_v=0, redirect_pc=0, instret=0.
  - alu_ok=0 and lsu_ok=0 while rst=1.
- Reset asserted mid-redirect: REDIRECT is abandoned and redirect_v=0 the next cycle.

## Timing
- Transfer in cycle N → rf_we/rf_waddr/rf_wdata/fwd_* valid in cycle N+1 for exactly one cycle, unless another transfer occurs in N+1.
- Branch transfer in cycle N → redirect_v=1 in N+1 → both ok=0 in N+1 → earliest next transfer in N+2.
- instret reflects a transfer in cycle N from N+1.
- Throughput: one transfer per cycle while rf_busy=0 and no branch.
- rf_busy is sampled combinationally in the transfer cycle. It has no effect on an already-registered write.
- Simultaneous ALU branch and LSU valid: arbitration applies as normal.
  - If ALU wins, the LSU entry waits through REDIRECT and is accepted at N+2. The flush of younger instructions is the producers' responsibility.

## Structure
- cpu_pkg holds:
  - xlen default
  - wb_state_e {RUN, REDIRECT}
  - wb_src_e {SRC_ALU, SRC_LSU}
- One sub-module, rr_arbiter2: 2-request round-robin with a pointer that updates on grant-taken, reusable by the issue stage.
- The write stage, FSM and counter live in writeback_unit.

## Test plan
- ALU only, rd=5, result=0x0000_00AA, rf_busy=0 → alu_ok=1 in N; rf_we=1, rf_waddr=5, rf_wdata=0xAA, fwd_v=1 in N+1; instret=1.
- Both valid for 4 cycles (ALU rd=1..4, LSU rd=9..12) → grants alternate ALU, LSU, ALU, LSU starting with ALU; rf_waddr sequence 1, 9, 2, 10.
- ALU branch, result=0x8000_0100 → rf_we=0, redirect_v=1 with redirect_pc=0x8000_0100 for one cycle; both ok=0 that cycle; instret+1.
- rf_busy=1 for 3 cycles with LSU valid → lsu_ok=0 for 3 cycles; accepted in the first cycle rf_busy=0; no lost or duplicated write.
- LSU rd=0 data=0xFFFF_FFFF → lsu_ok=1, rf_we=0, fwd_v=0, instret+1.
- instret preloaded to 2^cnt_w−1 via force, one transfer → instret=0. Assert rst during REDIRECT → redirect_v=0, state RUN and all outputs at their reset values the next cycle.
